// File: rtl/seg_scan_pkg.sv
// Shared constants, glyph table and FSM encoding for the 7-segment scan decoder.
package seg_scan_pkg;

  localparam int unsigned SEG_W  = 7;
  localparam int unsigned AN_W   = 4;
  localparam int unsigned NIB_W  = 4;
  localparam int unsigned WORD_W = 16;
  localparam int unsigned CNT_W  = 8;

  // Active-low cathode patterns, seg[0]=a ... seg[6]=g
  localparam logic [SEG_W-1:0] GLYPH_0 = 7'h40;
  localparam logic [SEG_W-1:0] GLYPH_1 = 7'h79;
  localparam logic [SEG_W-1:0] GLYPH_2 = 7'h24;
  localparam logic [SEG_W-1:0] GLYPH_3 = 7'h30;
  localparam logic [SEG_W-1:0] GLYPH_4 = 7'h19;
  localparam logic [SEG_W-1:0] GLYPH_5 = 7'h12;
  localparam logic [SEG_W-1:0] GLYPH_6 = 7'h02;
  localparam logic [SEG_W-1:0] GLYPH_7 = 7'h78;
  localparam logic [SEG_W-1:0] GLYPH_8 = 7'h00;
  localparam logic [SEG_W-1:0] GLYPH_9 = 7'h10;
  localparam logic [SEG_W-1:0] GLYPH_A = 7'h08;
  localparam logic [SEG_W-1:0] GLYPH_B = 7'h03;
  localparam logic [SEG_W-1:0] GLYPH_C = 7'h46;
  localparam logic [SEG_W-1:0] GLYPH_D = 7'h21;
  localparam logic [SEG_W-1:0] GLYPH_E = 7'h06;
  localparam logic [SEG_W-1:0] GLYPH_F = 7'h0E;

  localparam logic [SEG_W-1:0] SEG_ALL_OFF = 7'h7F;
  localparam logic [AN_W-1:0]  AN_ALL_OFF  = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  typedef struct packed {
    logic [AN_W-1:0]  an;
    logic [SEG_W-1:0] seg;
    logic             dp;
  } scan_t;

  localparam scan_t SCAN_IDLE = '{an: AN_ALL_OFF, seg: SEG_ALL_OFF, dp: 1'b1};

  // True when exactly one anode is driven low
  function automatic logic an_onehot(input logic [AN_W-1:0] an);
    return (an == 4'hE) || (an == 4'hD) || (an == 4'hB) || (an == 4'h7);
  endfunction

  function automatic logic [1:0] an_index(input logic [AN_W-1:0] an);
    logic [1:0] idx;
    case (an)
      4'hD:    idx = 2'd1;
      4'hB:    idx = 2'd2;
      4'h7:    idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/seg_glyph_decode.sv
// Combinational glyph-to-nibble decoder; unknown patterns give nibble 0 and invalid.
module seg_glyph_decode
  import seg_scan_pkg::*;
(
  input  logic [SEG_W-1:0] seg_i,
  output logic [NIB_W-1:0] nib_c_o,
  output logic             invalid_c_o
);

  always_comb begin
    nib_c_o     = '0;
    invalid_c_o = 1'b0;
    case (seg_i)
      GLYPH_0: nib_c_o = 4'h0;
      GLYPH_1: nib_c_o = 4'h1;
      GLYPH_2: nib_c_o = 4'h2;
      GLYPH_3: nib_c_o = 4'h3;
      GLYPH_4: nib_c_o = 4'h4;
      GLYPH_5: nib_c_o = 4'h5;
      GLYPH_6: nib_c_o = 4'h6;
      GLYPH_7: nib_c_o = 4'h7;
      GLYPH_8: nib_c_o = 4'h8;
      GLYPH_9: nib_c_o = 4'h9;
      GLYPH_A: nib_c_o = 4'hA;
      GLYPH_B: nib_c_o = 4'hB;
      GLYPH_C: nib_c_o = 4'hC;
      GLYPH_D: nib_c_o = 4'hD;
      GLYPH_E: nib_c_o = 4'hE;
      GLYPH_F: nib_c_o = 4'hF;
      default: invalid_c_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Watches multiplexed seg/an/dp lines, decodes each settled digit and rebuilds the 16-bit word.
// Define SEG_SCAN_SYNC_EN to put a 2-flop synchroniser on seg/an/dp (adds 2 cycles latency).
module seg_scan_decoder
  import seg_scan_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [SEG_W-1:0]  seg,
  input  logic [AN_W-1:0]   an,
  input  logic              dp,
  output logic [WORD_W-1:0] value,
  output logic              valid,
  output logic              err,
  output logic [AN_W-1:0]   dp_seen
);

  scan_t raw;
  scan_t cur;
  scan_t prev_q;

  assign raw = scan_t'({an, seg, dp});

`ifdef SEG_SCAN_SYNC_EN
  scan_t sync1_q;
  scan_t sync2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= SCAN_IDLE;
      sync2_q <= SCAN_IDLE;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

  assign cur = sync2_q;
`else
  assign cur = raw;
`endif

  // Previous-cycle sample used for the stability compare
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_q <= SCAN_IDLE;
    else        prev_q <= cur;
  end

  logic             same_c;
  logic             onehot_c;
  logic             an_chg_c;
  logic [1:0]       dig_c;
  logic [NIB_W-1:0] dec_nib_c;
  logic             dec_invalid_c;

  assign same_c   = (cur == prev_q);
  assign onehot_c = an_onehot(cur.an);
  assign an_chg_c = (cur.an != prev_q.an);
  assign dig_c    = an_index(cur.an);

  seg_glyph_decode u_decode (
    .seg_i       (cur.seg),
    .nib_c_o     (dec_nib_c),
    .invalid_c_o (dec_invalid_c)
  );

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc_c;
  logic             latch_c;

  assign cnt_inc_c = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Settle/hold sequencing: a digit latches once its sample has repeated SETTLE_CYCLES times
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    latch_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (onehot_c) state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (!onehot_c) begin
          state_d = ST_IDLE;
        end else if (same_c) begin
          cnt_d = cnt_inc_c;
          if (cnt_inc_c >= CNT_W'(SETTLE_CYCLES)) begin
            latch_c = 1'b1;
            cnt_d   = '0;
            state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (an_chg_c) state_d = onehot_c ? ST_SETTLE : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  logic [AN_W-1:0]             mask_q, mask_d;
  logic [AN_W-1:0]             bad_q, bad_d;
  logic [AN_W-1:0]             dpl_q;
  logic [AN_W-1:0][NIB_W-1:0]  nib_q;
  logic                        done_c;

  assign done_c = (mask_q == 4'hF);

  always_comb begin
    mask_d = done_c ? '0 : mask_q;
    bad_d  = done_c ? '0 : bad_q;
    if (latch_c) begin
      mask_d[dig_c] = 1'b1;
      bad_d[dig_c]  = dec_invalid_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q <= '0;
      bad_q  <= '0;
      dpl_q  <= '0;
      nib_q  <= '0;
    end else begin
      mask_q <= mask_d;
      bad_q  <= bad_d;
      if (latch_c) begin
        nib_q[dig_c] <= dec_nib_c;
        dpl_q[dig_c] <= ~cur.dp;
      end
    end
  end

  logic [WORD_W-1:0] value_q;
  logic              valid_q;
  logic              err_q;
  logic [AN_W-1:0]   dp_seen_q;

  // Frame publish: one cycle after the last slot of the frame lands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q   <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      dp_seen_q <= '0;
    end else begin
      valid_q <= done_c;
      if (done_c) begin
        value_q   <= nib_q;
        err_q     <= |bad_q;
        dp_seen_q <= dpl_q;
      end
    end
  end

  assign value   = value_q;
  assign valid   = valid_q;
  assign err     = err_q;
  assign dp_seen = dp_seen_q;

endmodule
